// File: rtl/util_spi_pkg.sv
// Shared types and constants for the SPI master slice: sequencer state encoding
// and {cpol,cpha} mode constants.
package util_spi_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'h01,
    ST_LOAD  = 8'h02,
    ST_SETUP = 8'h04,
    ST_RUN   = 8'h08,
    ST_DRAIN = 8'h10,
    ST_HOLD  = 8'h20,
    ST_GAP   = 8'h40
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/util_spi_wait_cnt.sv
// Loadable down-counter; done_o is high once the loaded count has expired.
// Loading N-1 keeps the owning state resident for N cycles.
module util_spi_wait_cnt
  import util_spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             done_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/util_spi_xfer_ctrl.sv
// SPI transaction sequencer: programs util_spi_clk_gen, frames chip select with
// setup/hold/gap timing, shifts MOSI, samples MISO and returns the rx word.
module util_spi_xfer_ctrl
  import util_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CNT_W           = 6,
  parameter logic [31:0] DEFAULT_CLK_DIV = 32'h00000064,
  parameter int unsigned CS_SETUP        = 4,
  parameter int unsigned CS_HOLD         = 4,
  parameter int unsigned CS_GAP          = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [CNT_W-1:0]      s_bits,
  input  logic [DIV_W-1:0]      cfg_baud_div,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  gen_en,
  output logic                  gen_load,
  output logic [DIV_W-1:0]      gen_baud_div,
  output logic                  gen_cpol,
  output logic                  gen_cpha,
  input  logic                  gen_shift_en,
  input  logic                  gen_latch_en,
  output logic                  spi_csn,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  spi_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, m_data_q, m_data_d;
  logic [CNT_W-1:0]      bits_q, bits_d, lat_cnt_q, lat_cnt_d, shf_cnt_q, shf_cnt_d;
  logic                  lsb_q, lsb_d;
  logic [DIV_W-1:0]      baud_q, baud_d, eff_div_q, eff_div_d, sh_amt_c;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  csn_q, csn_d, mosi_q, mosi_d, gen_en_q, gen_en_d;
  logic                  gen_load_q, gen_load_d, m_valid_q, m_valid_d;
  logic                  busy_q, busy_d, s_ready_q, s_ready_d;
  logic                  wait_load_c, wait_done;
  logic [DIV_W-1:0]      wait_val_c;

  // Zero or oversize counts select a full-width transfer.
  function automatic logic [CNT_W-1:0] clamp_bits(input logic [CNT_W-1:0] b);
    if (b == '0 || 32'(b) > DATA_WIDTH) return CNT_W'(DATA_WIDTH);
    return b;
  endfunction

  util_spi_wait_cnt u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wait_load_c),
    .load_val_i (wait_val_c),
    .done_o     (wait_done)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bits_d      = bits_q;
    lat_cnt_d   = lat_cnt_q;
    shf_cnt_d   = shf_cnt_q;
    lsb_d       = lsb_q;
    baud_d      = baud_q;
    eff_div_d   = eff_div_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    mosi_d      = mosi_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    wait_load_c = 1'b0;
    wait_val_c  = '0;
    sh_amt_c    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          bits_d    = clamp_bits(s_bits);
          sh_amt_c  = DIV_W'(DATA_WIDTH) - DIV_W'(bits_d);
          // MSB-first words are left-justified so the first bit is always the top bit.
          tx_d      = cfg_lsb_first ? s_data : (s_data << sh_amt_c);
          rx_d      = '0;
          lat_cnt_d = '0;
          shf_cnt_d = '0;
          lsb_d     = cfg_lsb_first;
          baud_d    = cfg_baud_div;
          cpol_d    = cfg_cpol;
          cpha_d    = cfg_cpha;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (baud_q > DIV_W'(1)) eff_div_d = baud_q;
        mosi_d      = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
        wait_load_c = 1'b1;
        wait_val_c  = DIV_W'(CS_SETUP - 1);
        state_d     = ST_SETUP;
      end
      ST_SETUP: begin
        if (wait_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Pulse 1 is skipped (bit 0 already presented); pulses past the count are dropped.
        if (gen_shift_en && (shf_cnt_q < bits_q)) begin
          shf_cnt_d = shf_cnt_q + CNT_W'(1);
          if (shf_cnt_q != '0) begin
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
            mosi_d = lsb_q ? tx_d[0] : tx_d[DATA_WIDTH-1];
          end
        end
        if (gen_latch_en) begin
          rx_d      = lsb_q ? {spi_miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], spi_miso};
          lat_cnt_d = lat_cnt_q + CNT_W'(1);
        end
        if (lat_cnt_d == bits_q) begin
          wait_load_c = 1'b1;
          wait_val_c  = eff_div_q - DIV_W'(1);
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wait_done) begin
          wait_load_c = 1'b1;
          wait_val_c  = DIV_W'(CS_HOLD - 1);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (wait_done) begin
          wait_load_c = 1'b1;
          wait_val_c  = DIV_W'(CS_GAP - 1);
          m_valid_d   = 1'b1;
          m_data_d    = lsb_q ? (rx_q >> (DIV_W'(DATA_WIDTH) - DIV_W'(bits_q))) : rx_q;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (wait_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d  = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    csn_d      = !(state_d inside {ST_SETUP, ST_RUN, ST_DRAIN, ST_HOLD});
    gen_en_d   = (state_d == ST_RUN);
    gen_load_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bits_q     <= '0;
      lat_cnt_q  <= '0;
      shf_cnt_q  <= '0;
      lsb_q      <= 1'b0;
      baud_q     <= DEFAULT_CLK_DIV;
      eff_div_q  <= DEFAULT_CLK_DIV;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      gen_en_q   <= 1'b0;
      gen_load_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      busy_q     <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bits_q     <= bits_d;
      lat_cnt_q  <= lat_cnt_d;
      shf_cnt_q  <= shf_cnt_d;
      lsb_q      <= lsb_d;
      baud_q     <= baud_d;
      eff_div_q  <= eff_div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      gen_en_q   <= gen_en_d;
      gen_load_q <= gen_load_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      busy_q     <= busy_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign gen_en       = gen_en_q;
  assign gen_load     = gen_load_q;
  assign gen_baud_div = baud_q;
  assign gen_cpol     = cpol_q;
  assign gen_cpha     = cpha_q;
  assign spi_csn      = csn_q;
  assign spi_mosi     = mosi_q;

endmodule

// File: tb/tb_util_spi_xfer_ctrl.sv
// Directed bench for util_spi_xfer_ctrl with a behavioural clock-generator model
// and a scoreboard of expected rx words.
module tb_util_spi_xfer_ctrl;
  import util_spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic [5:0]  s_bits;
  logic [31:0] cfg_baud_div;
  logic        cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic        m_valid, busy, gen_en, gen_load, gen_cpol, gen_cpha;
  logic [31:0] m_data, gen_baud_div;
  logic        gen_shift_en, gen_latch_en;
  logic        spi_csn, spi_mosi, spi_miso;
  int          miso_sel;

  always #5 clk = ~clk;

  assign spi_miso = (miso_sel == 0) ? spi_mosi : (miso_sel == 1);

  util_spi_xfer_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_bits(s_bits), .cfg_baud_div(cfg_baud_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .m_valid(m_valid), .m_data(m_data), .busy(busy),
    .gen_en(gen_en), .gen_load(gen_load), .gen_baud_div(gen_baud_div), .gen_cpol(gen_cpol),
    .gen_cpha(gen_cpha), .gen_shift_en(gen_shift_en), .gen_latch_en(gen_latch_en),
    .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // Generator model: alternating shift then latch pulses every div/2 cycles while enabled.
  logic [31:0] mdl_div;
  int          hcnt;
  logic        phase;
  always @(posedge clk) begin
    gen_shift_en <= 1'b0;
    gen_latch_en <= 1'b0;
    if (rst) begin
      mdl_div <= 32'd100;
      hcnt    <= 0;
      phase   <= 1'b0;
    end else begin
      if (gen_load && gen_baud_div > 32'd1) mdl_div <= gen_baud_div;
      if (!gen_en) begin
        hcnt  <= 0;
        phase <= 1'b0;
      end else if (hcnt == int'(mdl_div / 2) - 1) begin
        hcnt  <= 0;
        phase <= ~phase;
        if (!phase) gen_shift_en <= 1'b1;
        else        gen_latch_en <= 1'b1;
      end else begin
        hcnt <= hcnt + 1;
      end
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  int          r_lat, r_setup, r_post, r_mv, r_loads, r_ready_delay;
  logic [31:0] r_mosi, r_load_div;
  logic        r_ready_lo;
  int          high_run = 0, last_gap = 0, cpol_viol = 0;
  logic        prev_cpol = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_bits(input logic [5:0] b);
    return (b == 6'd0 || b > 6'd32) ? 32 : int'(b);
  endfunction

  function automatic logic [31:0] mask_of(input int nb);
    return (nb >= 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
  endfunction

  function automatic logic [31:0] exp_rx(input logic [31:0] d, input int nb, input int sel);
    if (sel == 0) return d & mask_of(nb);
    if (sel == 1) return mask_of(nb);
    return 32'h0;
  endfunction

  task automatic run_xfer(input logic [31:0] data, input logic [5:0] bits, input logic [31:0] div,
                          input logic [1:0] mode, input logic lsb, input logic hold, input int abort_at);
    logic seen_busy, seen_en, seen_mv, fin;
    s_data = data; s_bits = bits; cfg_baud_div = div;
    cfg_cpol = mode[1]; cfg_cpha = mode[0]; cfg_lsb_first = lsb; s_valid = 1'b1;
    exp_q.push_back(exp_rx(data, eff_bits(bits), miso_sel));
    r_lat = 0; r_setup = 0; r_post = 0; r_mv = 0; r_loads = 0; r_ready_delay = 0;
    r_mosi = '0; r_load_div = '0; r_ready_lo = 1'b1;
    seen_busy = 0; seen_en = 0; seen_mv = 0; fin = 0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
      if (seen_busy && !hold) s_valid = 1'b0;
      if (gen_load) begin r_loads++; r_load_div = gen_baud_div; end
      if (gen_latch_en) begin
        if (lsb && r_lat < 32) r_mosi[r_lat] = spi_mosi;
        else if (!lsb)         r_mosi = {r_mosi[30:0], spi_mosi};
        r_lat++;
      end
      if (gen_en) seen_en = 1;
      if (!spi_csn && !gen_en && !seen_en) r_setup++;
      if (!spi_csn && !gen_en && seen_en) r_post++;
      if (!spi_csn && gen_cpol !== prev_cpol) cpol_viol++;
      prev_cpol = gen_cpol;
      if (spi_csn) high_run++;
      else begin
        if (high_run > 0) last_gap = high_run;
        high_run = 0;
      end
      if (m_valid) begin
        r_mv++;
        if (!seen_mv) begin
          seen_mv = 1;
          r_ready_lo = s_ready;
          if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
          else                   check("m_data", m_data, exp_q.pop_front());
        end
      end
      if (seen_mv) begin
        if (s_ready) fin = 1;
        else r_ready_delay++;
      end
      if (abort_at != 0 && r_lat == abort_at) fin = 1;
    end
    if (!fin) check("timeout", 32'(fin), 32'd1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_bits = '0; cfg_baud_div = 32'd8;
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; miso_sel = 0;
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(spi_csn), 32'd1);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_gen_en", 32'(gen_en), 32'd0);
    check("rst_gen_load", 32'(gen_load), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_baud", gen_baud_div, 32'h64);
    check("rst_cpol", 32'(gen_cpol), 32'd0);
    check("rst_cpha", 32'(gen_cpha), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 32'd1);

    // Mode 0, MSB first, looped MISO
    miso_sel = 0;
    run_xfer(32'hA5, 6'd8, 32'd8, SPI_MODE0, 1'b0, 1'b0, 0);
    check("t1_latches", 32'(r_lat), 32'd8);
    check("t1_setup", 32'(r_setup), 32'd4);
    check("t1_post", 32'(r_post), 32'd12);
    check("t1_mvalid_cnt", 32'(r_mv), 32'd1);
    check("t1_ready_in_gap", 32'(r_ready_lo), 32'd0);
    check("t1_ready_delay", 32'(r_ready_delay), 32'd2);
    check("t1_mosi", r_mosi, 32'hA5);
    check("t1_loads", 32'(r_loads), 32'd1);

    // Mode 3, LSB first, MISO high
    miso_sel = 1;
    run_xfer(32'h1234, 6'd16, 32'd4, SPI_MODE3, 1'b1, 1'b0, 0);
    check("t2_latches", 32'(r_lat), 32'd16);
    check("t2_mosi", r_mosi, 32'h1234);
    check("t2_post", 32'(r_post), 32'd8);
    check("t2_cpol", 32'(gen_cpol), 32'd1);

    // Single-bit transfers
    miso_sel = 0;
    run_xfer(32'hFFFF_FFFE, 6'd1, 32'd4, SPI_MODE0, 1'b0, 1'b0, 0);
    check("t3a_latches", 32'(r_lat), 32'd1);
    miso_sel = 1;
    run_xfer(32'h0, 6'd1, 32'd4, SPI_MODE1, 1'b0, 1'b0, 0);
    check("t3b_latches", 32'(r_lat), 32'd1);

    // bits=0 selects full width
    miso_sel = 0;
    run_xfer(32'hDEAD_BEEF, 6'd0, 32'd6, SPI_MODE0, 1'b0, 1'b0, 0);
    check("t4_latches", 32'(r_lat), 32'd32);
    check("t4_mosi", r_mosi, 32'hDEAD_BEEF);
    check("t4_post", 32'(r_post), 32'd10);

    // div=1 is loaded but not adopted as the effective divider
    run_xfer(32'h9, 6'd4, 32'd1, SPI_MODE0, 1'b0, 1'b0, 0);
    check("t5_loads", 32'(r_loads), 32'd1);
    check("t5_load_div", r_load_div, 32'd1);
    check("t5_post", 32'(r_post), 32'd10);
    check("t5_latches", 32'(r_lat), 32'd4);

    // Oversize count clamps to 32, LSB first
    run_xfer(32'h0F0F_1234, 6'd40, 32'd4, SPI_MODE2, 1'b1, 1'b0, 0);
    check("t6_latches", 32'(r_lat), 32'd32);
    check("t6_mosi", r_mosi, 32'h0F0F_1234);

    // Back-to-back with s_valid held high
    cpol_viol = 0;
    run_xfer(32'h11, 6'd8, 32'd4, SPI_MODE0, 1'b0, 1'b1, 0);
    run_xfer(32'h22, 6'd8, 32'd4, SPI_MODE2, 1'b0, 1'b1, 0);
    check("t7_gap1", 32'(last_gap >= 2), 32'd1);
    check("t7_cpol_hi", 32'(gen_cpol), 32'd1);
    run_xfer(32'h33, 6'd8, 32'd4, SPI_MODE1, 1'b0, 1'b0, 0);
    check("t7_gap2", 32'(last_gap >= 2), 32'd1);
    check("t7_cpol_lo", 32'(gen_cpol), 32'd0);
    check("t7_cpol_in_cs", 32'(cpol_viol), 32'd0);

    // Reset during RUN at bit 5
    run_xfer(32'hABCD, 6'd16, 32'd8, SPI_MODE0, 1'b0, 1'b0, 5);
    check("t8_reached_bit5", 32'(r_lat), 32'd5);
    rst = 1'b1;
    #1;
    check("t8_csn", 32'(spi_csn), 32'd1);
    check("t8_gen_en", 32'(gen_en), 32'd0);
    check("t8_m_valid", 32'(m_valid), 32'd0);
    check("t8_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("t8_no_mvalid", 32'(m_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_xfer(32'h5A, 6'd8, 32'd8, SPI_MODE0, 1'b0, 1'b0, 0);
    check("t9_latches", 32'(r_lat), 32'd8);
    check("t9_mosi", r_mosi, 32'h5A);
    check("t9_mvalid_cnt", 32'(r_mv), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/util_spi_xfer_ctrl.md
Name: util_spi_xfer_ctrl

Overview:
- Transaction sequencer for the SPI clock generator (util_spi_clk_gen).
- Accepts one word per valid/ready handshake and programs the generator's divider and mode.
- Drives chip select with setup, hold and gap timing, and gates the generator enable.
- Shifts MOSI on the generator's shift_en pulses, samples MISO on its latch_en pulses, and returns the received word with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 32: maximum transfer length in bits; width of the tx/rx words.
- CNT_W, 6: width of s_bits; must satisfy 2^CNT_W > DATA_WIDTH.
- DEFAULT_CLK_DIV, 32'h00000064: divider assumed before the first valid load; must equal the generator's parameter.
- CS_SETUP, 4: clk cycles from CSN low to gen_en high.
- CS_HOLD, 4: clk cycles from the end of drain to CSN high.
- CS_GAP, 2: minimum clk cycles CSN stays high between transfers.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  transfer request.
- s_ready  out  1  high only in IDLE.
- s_data  in  DATA_WIDTH  tx word, right-aligned.
- s_bits  in  CNT_W  bit count; 0 or >DATA_WIDTH means DATA_WIDTH.
- cfg_baud_div  in  32  SCLK period in clk cycles.
- cfg_cpol  in  1  SPI clock polarity.
- cfg_cpha  in  1  SPI clock phase.
- cfg_lsb_first  in  1  bit order.
- m_valid  out  1  one-cycle pulse when a transfer completes.
- m_data  out  DATA_WIDTH  rx word, right-aligned; held until the next completion.
- busy  out  1  high whenever not in IDLE.
- gen_en  out  1  generator enable.
- gen_load  out  1  one-cycle divider load strobe.
- gen_baud_div  out  32  registered copy of cfg_baud_div.
- gen_cpol  out  1  registered copy of cfg_cpol.
- gen_cpha  out  1  registered copy of cfg_cpha.
- gen_shift_en  in  1  generator shift strobe.
- gen_latch_en  in  1  generator latch strobe.
- spi_csn  out  1  chip select, active low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.

Behaviour:
- Reset (async assert, sync release):
  - spi_csn=1, spi_mosi=0, gen_en=0, gen_load=0, m_valid=0, busy=0, s_ready=0, m_data=0.
  - gen_baud_div=DEFAULT_CLK_DIV, gen_cpol=0, gen_cpha=0, eff_div=DEFAULT_CLK_DIV.
  - FSM enters IDLE; s_ready=1 from the first cycle after release.
- Reset asserted mid-transfer aborts immediately: CSN high, no m_valid.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: on s_valid&&s_ready, capture s_data, the clamped bit count, all cfg_* inputs and bit order, and go to LOAD.
  - LOAD (1 cycle):
    - gen_load=1.
    - gen_cpol/gen_cpha/gen_baud_div update, with CSN still high, so an idle polarity change never glitches inside a CS window.
    - eff_div <= cfg_baud_div only if cfg_baud_div>1, mirroring the generator's acceptance rule.
    - spi_mosi <= first tx bit (MSB of the active bit count, or LSB when lsb_first).
    - Go to SETUP.
  - SETUP: CSN=0; after CS_SETUP cycles go to RUN.
  - RUN:
    - gen_en=1.
    - On gen_shift_en, spi_mosi advances to the next tx bit. The first gen_shift_en of a transfer is ignored because bit 0 was presented in LOAD. Shift pulses beyond the bit count are ignored.
    - On gen_latch_en, spi_miso shifts into the rx register and the latch count increments.
    - When latch count reaches the bit count, go to DRAIN.
  - DRAIN: gen_en=0 from the cycle after the last latch; stay eff_div cycles so the generator finishes its current or post half-period.
  - HOLD: CSN=0 for CS_HOLD cycles, then go to GAP.
  - GAP:
    - CSN=1.
    - On entry: m_valid=1 for one cycle and m_data=rx word, right-aligned in the chosen bit order.
    - After CS_GAP cycles go to IDLE.
- Edge cases:
  - 1-bit transfer: the single latch moves RUN to DRAIN.
  - gen_latch_en and gen_shift_en in the same cycle: both are honoured.
  - s_valid while busy is not accepted; s_data/cfg_* may change freely while busy.
  - Latch counter width is CNT_W, so no wrap occurs.

Decomposition:
- Shared package util_spi_pkg:
  - FSM state encodings (IDLE, LOAD, SETUP, RUN, DRAIN, HOLD, GAP, one-hot 8-bit, as in the generator).
  - Mode constants SPI_MODE0..3 as {cpol,cpha}.
- Sub-module util_spi_wait_cnt: loadable 32-bit down-counter with a done flag, reused for SETUP, DRAIN, HOLD and GAP.
- The generator is not instantiated here. The util_spi_master top wires this block to util_spi_clk_gen.

Test Plan:
- Mode 0, div=8, bits=8, s_data=0xA5, MSB first, MISO looped from MOSI:
  - Exactly 8 latches; CSN low 4 cycles before gen_en.
  - m_valid once, m_data=0xA5; s_ready low until GAP ends.
- Mode 3, div=4, bits=16, s_data=0x1234, lsb_first, MISO tied 1:
  - 16 latches, m_data=0xFFFF.
  - MOSI sequence reads 0x1234 LSB first on leading edges.
- bits=1 and bits=0:
  - bits=1: one latch, m_data[0]=MISO.
  - bits=0: 32 latches; m_data equals the full 32-bit looped word.
- cfg_baud_div=1 after a div=6 transfer:
  - gen_load pulses, but drain lasts 6 cycles (eff_div kept).
- Back-to-back requests with s_valid held high:
  - CSN high at least CS_GAP=2 cycles between transfers.
  - gen_cpol changes only while CSN=1.
- rst asserted mid-RUN at bit 5:
  - Same cycle: CSN=1, gen_en=0, no m_valid.
  - After release, the next transfer completes normally.
